// File: rtl/byte_read_port.sv
// Avalon-MM slave exposing a synchronized 8-bit input with per-bit edge capture,
// a saturating edge counter and a maskable level interrupt.
module byte_read_port #(
  parameter bit CAPTURE_FALLING = 1'b0
) (
  input  logic       csi_clk,
  input  logic       csi_reset,
  input  logic [3:0] avs_s1_address,
  input  logic       avs_s1_read,
  output logic [7:0] avs_s1_readdata,
  input  logic       avs_s1_write,
  input  logic [7:0] avs_s1_writedata,
  input  logic [7:0] user_datain_0,
  output logic       ins_irq0_irq
);

  localparam logic [3:0] AddrData  = 4'd0;
  localparam logic [3:0] AddrCount = 4'd1;
  localparam logic [3:0] AddrMask  = 4'd2;
  localparam logic [3:0] AddrCap   = 4'd3;

  logic [7:0] s1_q, s2_q, prev_q;
  logic [1:0] warm_q, warm_d;
  logic [7:0] cap_q, cap_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] mask_q, mask_d;
  logic [7:0] rdata_q, rdata_d;
  logic [7:0] edge_hit;
  logic [7:0] cap_clr;

  always_comb begin
    warm_d = (warm_q == 2'd3) ? warm_q : warm_q + 2'd1;

    // Edges are ignored until the pipeline has held valid samples for three cycles,
    // so an input already high at reset release does not look like a fresh edge.
    edge_hit = CAPTURE_FALLING ? (~s2_q & prev_q) : (s2_q & ~prev_q);
    if (warm_q != 2'd3) begin
      edge_hit = 8'h00;
    end

    cap_clr = (avs_s1_write && avs_s1_address == AddrCap) ? avs_s1_writedata : 8'h00;
    cap_d   = (cap_q & ~cap_clr) | edge_hit;

    cnt_d = (avs_s1_write && avs_s1_address == AddrCount) ? 8'h00 : cnt_q;
    if ((|edge_hit) && cnt_d != 8'hFF) begin
      cnt_d = cnt_d + 8'd1;
    end

    mask_d = (avs_s1_write && avs_s1_address == AddrMask) ? avs_s1_writedata : mask_q;

    rdata_d = rdata_q;
    if (avs_s1_read) begin
      case (avs_s1_address)
        AddrData:  rdata_d = s2_q;
        AddrCount: rdata_d = cnt_q;
        AddrMask:  rdata_d = mask_q;
        AddrCap:   rdata_d = cap_q;
        default:   rdata_d = 8'h00;
      endcase
    end
  end

  always_ff @(posedge csi_clk or posedge csi_reset) begin
    if (csi_reset) begin
      s1_q    <= 8'h00;
      s2_q    <= 8'h00;
      prev_q  <= 8'h00;
      warm_q  <= 2'd0;
      cap_q   <= 8'h00;
      cnt_q   <= 8'h00;
      mask_q  <= 8'h00;
      rdata_q <= 8'h00;
    end else begin
      s1_q    <= user_datain_0;
      s2_q    <= s1_q;
      prev_q  <= s2_q;
      warm_q  <= warm_d;
      cap_q   <= cap_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      rdata_q <= rdata_d;
    end
  end

  assign avs_s1_readdata = rdata_q;
  assign ins_irq0_irq    = |(cap_q & mask_q);

endmodule

// File: tb/tb_byte_read_port.sv
// Bench for byte_read_port: one rising-edge and one falling-edge instance driven
// side by side and compared against a sample-history reference model.
module tb_byte_read_port;

  logic       clk;
  logic       rst;
  logic [3:0] addr  [2];
  logic       rd    [2];
  logic       wr    [2];
  logic [7:0] wdata [2];
  logic [7:0] din   [2];
  logic [7:0] rdata [2];
  logic       irq   [2];

  int n_cmp;
  int n_fail;

  // Reference model state
  logic [7:0] m_cap  [2];
  logic [7:0] m_cnt  [2];
  logic [7:0] m_mask [2];
  logic [7:0] m_rd   [2];
  int         m_n    [2];
  logic [7:0] hist0[$];
  logic [7:0] hist1[$];

  byte_read_port #(.CAPTURE_FALLING(1'b0)) dut_rise (
    .csi_clk          (clk),
    .csi_reset        (rst),
    .avs_s1_address   (addr[0]),
    .avs_s1_read      (rd[0]),
    .avs_s1_readdata  (rdata[0]),
    .avs_s1_write     (wr[0]),
    .avs_s1_writedata (wdata[0]),
    .user_datain_0    (din[0]),
    .ins_irq0_irq     (irq[0])
  );

  byte_read_port #(.CAPTURE_FALLING(1'b1)) dut_fall (
    .csi_clk          (clk),
    .csi_reset        (rst),
    .avs_s1_address   (addr[1]),
    .avs_s1_read      (rd[1]),
    .avs_s1_readdata  (rdata[1]),
    .avs_s1_write     (wr[1]),
    .avs_s1_writedata (wdata[1]),
    .user_datain_0    (din[1]),
    .ins_irq0_irq     (irq[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  // Input byte sampled `age` clock edges ago (age 1 = most recent); zero before release.
  function automatic logic [7:0] past(input int k, input int age);
    if (k == 0) return (hist0.size() >= age) ? hist0[age-1] : 8'h00;
    return (hist1.size() >= age) ? hist1[age-1] : 8'h00;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cap[k] = 8'h00; m_cnt[k] = 8'h00; m_mask[k] = 8'h00; m_rd[k] = 8'h00; m_n[k] = 0;
    end
    hist0.delete();
    hist1.delete();
  endtask

  // One clock edge: predict, clock, commit model, compare outputs, drop strobes.
  task automatic tick();
    logic [7:0] ncap [2];
    logic [7:0] nmask[2];
    logic [7:0] nrd  [2];
    int         ncnt [2];
    logic [7:0] cur, old, hit, clr;
    for (int k = 0; k < 2; k++) begin
      cur = past(k, 2);
      old = past(k, 3);
      hit = 8'h00;
      if (m_n[k] >= 3) hit = (k == 1) ? (old & ~cur) : (cur & ~old);
      clr = (wr[k] && addr[k] == 4'd3) ? wdata[k] : 8'h00;
      ncap[k] = (m_cap[k] & ~clr) | hit;
      ncnt[k] = (wr[k] && addr[k] == 4'd1) ? 0 : int'(m_cnt[k]);
      if (hit != 8'h00 && ncnt[k] < 255) ncnt[k] = ncnt[k] + 1;
      nmask[k] = (wr[k] && addr[k] == 4'd2) ? wdata[k] : m_mask[k];
      nrd[k] = m_rd[k];
      if (rd[k]) begin
        case (addr[k])
          4'd0:    nrd[k] = cur;
          4'd1:    nrd[k] = m_cnt[k];
          4'd2:    nrd[k] = m_mask[k];
          4'd3:    nrd[k] = m_cap[k];
          default: nrd[k] = 8'h00;
        endcase
      end
    end
    hist0.push_front(din[0]);
    hist1.push_front(din[1]);
    if (hist0.size() > 8) void'(hist0.pop_back());
    if (hist1.size() > 8) void'(hist1.pop_back());
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      m_cap[k]  = ncap[k];
      m_cnt[k]  = 8'(ncnt[k]);
      m_mask[k] = nmask[k];
      m_rd[k]   = nrd[k];
      m_n[k]++;
      chk($sformatf("rdata%0d", k), rdata[k], m_rd[k]);
      chk($sformatf("irq%0d", k), {7'b0, irq[k]}, {7'b0, |(m_cap[k] & m_mask[k])});
      rd[k] = 1'b0;
      wr[k] = 1'b0;
    end
  endtask

  task automatic bus_wr(input int k, input logic [3:0] a, input logic [7:0] d);
    addr[k] = a; wdata[k] = d; wr[k] = 1'b1;
    tick();
  endtask

  task automatic bus_rd(input int k, input logic [3:0] a);
    addr[k] = a; rd[k] = 1'b1;
    tick();
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b1;
    for (int k = 0; k < 2; k++) begin
      addr[k] = 4'd0; rd[k] = 1'b0; wr[k] = 1'b0; wdata[k] = 8'h00; din[k] = 8'h00;
    end
    // Input already high across reset release must not register as an edge.
    din[0] = 8'hFF;
    #1;
    chk("reset_rdata", rdata[0], 8'h00);
    chk("reset_irq", {7'b0, irq[0]}, 8'h00);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    repeat (10) tick();
    bus_rd(0, 4'd3);
    chk("warmup_cap", rdata[0], 8'h00);
    bus_rd(0, 4'd1);
    chk("warmup_cnt", rdata[0], 8'h00);

    din[0] = 8'h00;
    repeat (4) tick();
    bus_wr(0, 4'd2, 8'hFF);
    din[0] = 8'h5A;
    repeat (3) tick();
    chk("edge_irq", {7'b0, irq[0]}, 8'h01);
    bus_rd(0, 4'd3);
    chk("edge_cap", rdata[0], 8'h5A);
    bus_rd(0, 4'd1);
    chk("edge_cnt", rdata[0], 8'h01);
    bus_rd(0, 4'd0);
    chk("data_rd", rdata[0], 8'h5A);
    chk("bad_addr_pre", rdata[0], 8'h5A);
    bus_rd(0, 4'd9);
    chk("bad_addr", rdata[0], 8'h00);

    bus_wr(0, 4'd3, 8'h0A);
    chk("w1c_irq", {7'b0, irq[0]}, 8'h01);
    bus_rd(0, 4'd3);
    chk("w1c_cap", rdata[0], 8'h50);
    bus_wr(0, 4'd3, 8'h50);
    chk("w1c_irq_low", {7'b0, irq[0]}, 8'h00);
    bus_rd(0, 4'd3);
    chk("w1c_cap_zero", rdata[0], 8'h00);

    // Read and write of the same register in one cycle returns the old value.
    addr[0] = 4'd2; wdata[0] = 8'h0F; wr[0] = 1'b1; rd[0] = 1'b1;
    tick();
    chk("rw_same", rdata[0], 8'hFF);

    // Bit 0 rises on the very edge a write-1-clear of bit 0 lands.
    din[0] = 8'h5B;
    tick();
    tick();
    bus_wr(0, 4'd3, 8'h01);
    bus_rd(0, 4'd3);
    chk("edge_vs_clr", rdata[0], 8'h01);
    chk("irq_before_rst", {7'b0, irq[0]}, 8'h01);

    // Asynchronous reset pulse between clock edges.
    #2;
    rst = 1'b1;
    #1;
    chk("async_irq", {7'b0, irq[0]}, 8'h00);
    chk("async_rdata", rdata[0], 8'h00);
    #1;
    rst = 1'b0;
    model_reset();
    din[0] = 8'h00;
    repeat (5) tick();

    // Falling-edge instance: 300 falls of bit 7 saturate the counter.
    for (int i = 0; i < 600; i++) begin
      din[1] = {~din[1][7], 7'($urandom_range(0, 127))};
      tick();
    end
    din[1] = 8'h00;
    repeat (4) tick();
    bus_rd(1, 4'd1);
    chk("sat_cnt", rdata[1], 8'hFF);
    bus_wr(1, 4'd1, 8'h00);
    bus_rd(1, 4'd1);
    chk("cnt_clear", rdata[1], 8'h00);

    // Randomized bus traffic and input changes on both instances.
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 2; k++) begin
        din[k]   = 8'($urandom);
        addr[k]  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
        wdata[k] = 8'($urandom);
        rd[k]    = 1'($urandom);
        wr[k]    = ($urandom_range(0, 3) == 0);
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
